div_radix2: RTL

//   Iterative radix-2 restoring divider serving ex for DIV/DIVU.
//   ex drives operands and start_i, then holds start_i until ready_o.

---
 rtl/div_radix2.sv | 129 ++++++++++++
 1 files changed

// File: rtl/div_radix2.sv
// Iterative radix-2 restoring divider for DIV/DIVU, one quotient bit per cycle; result = {remainder, quotient}.
// Latency: DATA_W+1 edges (zero divisor 2, early-out 1); start_i held until ready_o, annul_i aborts. Option: DIV_EARLY_OUT_EN.
// Backpressure: ready_o/result_o held while start_i stays high; dropping start_i in END releases the unit.
module div_radix2 #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    typedef enum logic [1:0] {FREE, BY_ZERO, ON, END} state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   dvd_q;   // dividend bits shift out, quotient bits shift in
    logic [DATA_W-1:0]   rem_q;
    logic [DATA_W-1:0]   dvs_q;
    logic                neg_q;
    logic                neg_r;

    logic [DATA_W-1:0]   mag1;
    logic [DATA_W-1:0]   mag2;
    logic [DATA_W:0]     trial;
    logic [DATA_W:0]     diff;
    logic                take;
    logic [DATA_W-1:0]   rem_nxt;
    logic [DATA_W-1:0]   quo_nxt;
    logic                last;
    logic                early;

    always_comb begin
        mag1    = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
        mag2    = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
        trial   = {rem_q, dvd_q[DATA_W-1]};
        diff    = trial - {1'b0, dvs_q};
        take    = ~diff[DATA_W];
        rem_nxt = take ? diff[DATA_W-1:0] : trial[DATA_W-1:0];
        quo_nxt = {dvd_q[DATA_W-2:0], take};
        last    = (cnt == CNT_W'(DATA_W - 1));
`ifdef DIV_EARLY_OUT_EN
        early   = (mag1 < mag2);
`else
        early   = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FREE;
            cnt      <= '0;
            dvd_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            ready_o  <= 1'b0;
            result_o <= '0;
        end else begin
            case (state)
                FREE: begin
                    ready_o  <= 1'b0;
                    result_o <= '0;
                    if (start_i && !annul_i) begin
                        dvs_q <= mag2;
                        dvd_q <= mag1;
                        rem_q <= '0;
                        cnt   <= '0;
                        neg_q <= signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                        neg_r <= signed_div_i & opdata1_i[DATA_W-1];
                        if (opdata2_i == '0) begin
                            state <= BY_ZERO;
                        end else if (early) begin
                            // |dividend| < |divisor|: quotient 0, remainder is the dividend as given
                            dvd_q <= '0;
                            rem_q <= opdata1_i;
                            state <= END;
                        end else begin
                            state <= ON;
                        end
                    end
                end
                BY_ZERO: begin
                    if (annul_i) begin
                        state <= FREE;
                    end else begin
                        dvd_q <= '0;
                        rem_q <= '0;
                        state <= END;
                    end
                end
                ON: begin
                    if (annul_i) begin
                        state <= FREE;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (last) begin
                            dvd_q <= neg_q ? -quo_nxt : quo_nxt;
                            rem_q <= neg_r ? -rem_nxt : rem_nxt;
                            state <= END;
                        end else begin
                            dvd_q <= quo_nxt;
                            rem_q <= rem_nxt;
                        end
                    end
                end
                END: begin
                    if (start_i) begin
                        ready_o  <= 1'b1;
                        result_o <= {rem_q, dvd_q};
                    end else begin
                        ready_o  <= 1'b0;
                        result_o <= '0;
                        state    <= FREE;
                    end
                end
                default: state <= FREE;
            endcase
        end
    end

endmodule
